// File: rtl/qam16_symbol_sequencer_pkg.sv
// qam16_pkg: shared constants, FSM state type and the symbols-per-word helper
// for the QAM-16 symbol sequencer.
//   QAM16_AMPLITUDE_DEFAULT    : base amplitude A = 1/sqrt(10) in Q1.15
//   QAM16_AMPLITUDE_3A_DEFAULT : outer-ring amplitude 3A for the default A
//   qam16_state_t              : sequencer FSM states (IDLE, SEND)
//   qam16_syms()               : number of 4-bit symbols carried by a word
package qam16_pkg;

    localparam logic [15:0] QAM16_AMPLITUDE_DEFAULT    = 16'h287A;
    localparam logic [17:0] QAM16_AMPLITUDE_3A_DEFAULT =
        {2'b00, QAM16_AMPLITUDE_DEFAULT} + {2'b00, QAM16_AMPLITUDE_DEFAULT} +
        {2'b00, QAM16_AMPLITUDE_DEFAULT};

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } qam16_state_t;

    function automatic int qam16_syms(input int data_width);
        return data_width / 4;
    endfunction

endpackage

// File: rtl/qam16_symbol_sequencer_if.sv
// Stream bundle for the QAM-16 symbol sequencer.
//   s_valid/s_ready/s_data : input word stream (word producer drives valid/data)
//   m_valid/m_ready        : output symbol handshake
//   m_i/m_q                : signed I/Q sample of the current symbol
//   m_last                 : marks the final symbol of a word
// Modport slave is the sequencer's view, master is the surrounding logic's view.
interface qam16_symbol_sequencer_if #(
    parameter int IN_W    = 16,
    parameter int OUT_I_W = 16,
    parameter int OUT_Q_W = 16
);
    logic                      s_valid;
    logic                      s_ready;
    logic [IN_W-1:0]           s_data;
    logic                      m_valid;
    logic                      m_ready;
    logic signed [OUT_I_W-1:0] m_i;
    logic signed [OUT_Q_W-1:0] m_q;
    logic                      m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_i, m_q, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_i, m_q, m_last
    );
endinterface

// File: rtl/qam16_symbol_sequencer_map.sv
// qam16_symbol_map: combinational QAM-16 mapper for one 4-bit nibble.
//   nibble : b[3:0]; b0/b1 select the I/Q sign (0 = positive),
//            b2/b3 select the I/Q magnitude (1 = 3A, 0 = A)
//   sym_i  : A*(1-2*b0)*(1+2*b2), low OUT_I_W bits of the full-precision value
//   sym_q  : A*(1-2*b1)*(1+2*b3), low OUT_Q_W bits of the full-precision value
module qam16_symbol_map
    import qam16_pkg::*;
#(
    parameter int              AMP_W     = 16,
    parameter logic [AMP_W-1:0] AMPLITUDE = QAM16_AMPLITUDE_DEFAULT,
    parameter int              OUT_I_W   = 16,
    parameter int              OUT_Q_W   = 16
) (
    input  logic [3:0]                nibble,
    output logic signed [OUT_I_W-1:0] sym_i,
    output logic signed [OUT_Q_W-1:0] sym_q
);
    // Wide enough for +/-3A and for sign extension into either output width,
    // so taking the low bits is always a plain two's-complement truncation.
    localparam int MAX_OUT_W = (OUT_I_W > OUT_Q_W) ? OUT_I_W : OUT_Q_W;
    localparam int FULL_W    = AMP_W + 3 + MAX_OUT_W;

    localparam logic signed [FULL_W-1:0] AMP_1 = FULL_W'(AMPLITUDE);
    localparam logic signed [FULL_W-1:0] AMP_3 = AMP_1 + AMP_1 + AMP_1;

    logic signed [FULL_W-1:0] mag_i;
    logic signed [FULL_W-1:0] mag_q;
    logic signed [FULL_W-1:0] full_i;
    logic signed [FULL_W-1:0] full_q;

    always_comb begin
        mag_i  = nibble[2] ? AMP_3 : AMP_1;
        mag_q  = nibble[3] ? AMP_3 : AMP_1;
        full_i = nibble[0] ? -mag_i : mag_i;
        full_q = nibble[1] ? -mag_q : mag_q;
        sym_i  = full_i[OUT_I_W-1:0];
        sym_q  = full_q[OUT_Q_W-1:0];
    end
endmodule

// File: rtl/qam16_symbol_sequencer.sv
// qam16_symbol_sequencer: serialises each accepted input word into SYMS
// QAM-16 symbols (lowest nibble first), one registered I/Q pair per output beat.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   enable : gates acceptance of new words; a word in flight always completes
//   busy   : high while a word is being sent
//   bus    : slave modport of qam16_symbol_sequencer_if (word in, symbols out)
module qam16_symbol_sequencer
    import qam16_pkg::*;
#(
    parameter int          INPUT_DATA_WIDTH    = 16,
    parameter int          OUTPUT_DATA_WIDTH_I = 16,
    parameter int          OUTPUT_DATA_WIDTH_Q = 16,
    parameter logic [15:0] QAM16_AMPLITUDE     = QAM16_AMPLITUDE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    output logic                    busy,
    qam16_symbol_sequencer_if.slave bus
);
    localparam int SYMS  = qam16_syms(INPUT_DATA_WIDTH);
    localparam int IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int NIB_N = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS - 1);

    qam16_state_t                          state_reg;
    logic [IDX_W-1:0]                      sym_idx_reg;
    logic [INPUT_DATA_WIDTH-1:0]           word_reg;
    logic                                  m_valid_reg;
    logic                                  m_last_reg;
    logic signed [OUTPUT_DATA_WIDTH_I-1:0] m_i_reg;
    logic signed [OUTPUT_DATA_WIDTH_Q-1:0] m_q_reg;

    logic                                  accept;
    logic                                  fire;
    logic [IDX_W-1:0]                      idx_next;
    logic [3:0]                            map_nibble;
    logic signed [OUTPUT_DATA_WIDTH_I-1:0] map_i;
    logic signed [OUTPUT_DATA_WIDTH_Q-1:0] map_q;
    logic [3:0]                            nibble_arr [NIB_N];

    // Nibble table padded to a power of two so idx_next can never index
    // outside the array, whatever SYMS is.
    for (genvar gi = 0; gi < NIB_N; gi++) begin : g_nib
        if (gi < SYMS) begin : g_word
            assign nibble_arr[gi] = word_reg[4*gi +: 4];
        end else begin : g_pad
            assign nibble_arr[gi] = 4'h0;
        end
    end

    // A new word can be taken while idle, or in the very cycle the last symbol
    // of the current word is handed off, which removes the inter-word bubble.
    assign bus.s_ready = enable &&
                         ((state_reg == IDLE) || (m_valid_reg && bus.m_ready && m_last_reg));
    assign accept      = bus.s_valid && bus.s_ready;
    assign fire        = m_valid_reg && bus.m_ready;
    assign idx_next    = sym_idx_reg + IDX_W'(1);

    // The mapper always computes the symbol that will be registered next:
    // symbol 0 of the incoming word on accept, otherwise the following nibble
    // of the held word.
    assign map_nibble = accept ? bus.s_data[3:0] : nibble_arr[idx_next];

    qam16_symbol_map #(
        .AMP_W     (16),
        .AMPLITUDE (QAM16_AMPLITUDE),
        .OUT_I_W   (OUTPUT_DATA_WIDTH_I),
        .OUT_Q_W   (OUTPUT_DATA_WIDTH_Q)
    ) u_map (
        .nibble (map_nibble),
        .sym_i  (map_i),
        .sym_q  (map_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sym_idx_reg <= '0;
            word_reg    <= '0;
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            m_i_reg     <= '0;
            m_q_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg   <= SEND;
                        word_reg    <= bus.s_data;
                        sym_idx_reg <= '0;
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= (SYMS == 1);
                        m_i_reg     <= map_i;
                        m_q_reg     <= map_q;
                    end
                end
                SEND: begin
                    if (fire && !m_last_reg) begin
                        sym_idx_reg <= idx_next;
                        m_last_reg  <= (idx_next == LAST_IDX);
                        m_i_reg     <= map_i;
                        m_q_reg     <= map_q;
                    end else if (fire && accept) begin
                        word_reg    <= bus.s_data;
                        sym_idx_reg <= '0;
                        m_last_reg  <= (SYMS == 1);
                        m_i_reg     <= map_i;
                        m_q_reg     <= map_q;
                    end else if (fire) begin
                        state_reg   <= IDLE;
                        sym_idx_reg <= '0;
                        m_valid_reg <= 1'b0;
                        m_last_reg  <= 1'b0;
                        m_i_reg     <= '0;
                        m_q_reg     <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.m_valid = m_valid_reg;
    assign bus.m_last  = m_last_reg;
    assign bus.m_i     = m_i_reg;
    assign bus.m_q     = m_q_reg;
    assign busy        = (state_reg == SEND);

endmodule

// File: tb/tb_qam16_symbol_sequencer.sv
module tb_qam16_symbol_sequencer;
    localparam logic [15:0] A   = 16'h287A;
    localparam logic [15:0] NA  = 16'hD786;
    localparam logic [15:0] A3  = 16'h796E;
    localparam logic [15:0] NA3 = 16'h8692;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic busy;
    int   n_cmp  = 0;
    int   n_fail = 0;

    qam16_symbol_sequencer_if #(.IN_W(16), .OUT_I_W(16), .OUT_Q_W(16)) bus ();

    qam16_symbol_sequencer #(
        .INPUT_DATA_WIDTH    (16),
        .OUTPUT_DATA_WIDTH_I (16),
        .OUTPUT_DATA_WIDTH_Q (16),
        .QAM16_AMPLITUDE     (16'h287A)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Per-axis reference: sign bit 1 -> negative, magnitude bit 1 -> 3A.
    function automatic logic [15:0] exp_axis(input logic sgn, input logic big);
        case ({big, sgn})
            2'b00:   return A;
            2'b01:   return NA;
            2'b10:   return A3;
            default: return NA3;
        endcase
    endfunction

    function automatic logic [31:0] exp_sym(input logic [3:0] n);
        return {exp_axis(n[0], n[2]), exp_axis(n[1], n[3])};
    endfunction

    task automatic test_reset;
        rst_n = 1'b1; enable = 1'b0; bus.s_valid = 1'b0; bus.s_data = 16'h0; bus.m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.m_valid, bus.m_last, bus.m_i, bus.m_q, busy} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b l=%b i=%h q=%h busy=%b, want all 0",
                     bus.m_valid, bus.m_last, bus.m_i, bus.m_q, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sready_disabled: got %b want 0", bus.s_ready);
        end
        enable = 1'b1;
        #1;
        n_cmp++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_sready_enabled: got %b want 1", bus.s_ready);
        end
    endtask

    task automatic test_single_word;
        @(negedge clk);
        enable = 1'b1; bus.m_ready = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'h0000;
        #1;
        n_cmp++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_sready_idle: got %b want 1", bus.s_ready);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) begin bus.s_valid = 1'b0; bus.s_data = 16'hFFFF; end
            #1;
            $display("single beat %0d: v=%b l=%b i=%h q=%h", b, bus.m_valid, bus.m_last, bus.m_i, bus.m_q);
            n_cmp++;
            if ({bus.m_valid, bus.m_last, bus.m_i, bus.m_q, busy} !== {1'b1, (b == 3), A, A, 1'b1}) begin
                n_fail++;
                $display("FAIL single_beat%0d: got v=%b l=%b i=%h q=%h busy=%b, want v=1 l=%b i=%h q=%h busy=1",
                         b, bus.m_valid, bus.m_last, bus.m_i, bus.m_q, busy, (b == 3), A, A);
            end
            if (b == 3) begin
                n_cmp++;
                if (bus.s_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_sready_last: got %b want 1", bus.s_ready);
                end
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.m_valid, bus.m_i, bus.m_q, busy} !== 34'h0) begin
            n_fail++;
            $display("FAIL single_idle_after: got v=%b i=%h q=%h busy=%b, want all 0",
                     bus.m_valid, bus.m_i, bus.m_q, busy);
        end
    endtask

    task automatic test_nibble_sweep;
        logic [15:0] words [5];
        logic [31:0] f5a1  [4];
        logic [31:0] e;
        words = '{16'hF5A1, 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        // Hand-derived from I=A(1-2b0)(1+2b2), Q=A(1-2b1)(1+2b3): nibbles 1, A, 5, F.
        f5a1  = '{{NA, A}, {A, NA3}, {NA3, A}, {NA3, NA3}};
        bus.m_ready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            bus.s_valid = 1'b1; bus.s_data = words[w];
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                if (b == 0) bus.s_valid = 1'b0;
                #1;
                e = (w == 0) ? f5a1[b] : exp_sym(words[w][4*b +: 4]);
                $display("sweep word %h beat %0d: i=%h q=%h", words[w], b, bus.m_i, bus.m_q);
                n_cmp++;
                if ({bus.m_valid, bus.m_last, bus.m_i, bus.m_q} !== {1'b1, (b == 3), e}) begin
                    n_fail++;
                    $display("FAIL sweep_%h_beat%0d: got v=%b l=%b i=%h q=%h, want v=1 l=%b i=%h q=%h",
                             words[w], b, bus.m_valid, bus.m_last, bus.m_i, bus.m_q, (b == 3), e[31:16], e[15:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] cur;
        logic [31:0] e;
        w1 = 16'h8421; w2 = 16'h5A3C;
        @(negedge clk);
        bus.m_ready = 1'b1; bus.s_valid = 1'b1; bus.s_data = w1;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            if (b == 0) bus.s_data = w2;
            if (b == 4) bus.s_valid = 1'b0;
            #1;
            cur = (b < 4) ? w1 : w2;
            e   = exp_sym(cur[4*(b % 4) +: 4]);
            $display("b2b beat %0d: v=%b l=%b i=%h q=%h", b, bus.m_valid, bus.m_last, bus.m_i, bus.m_q);
            n_cmp++;
            if ({bus.m_valid, bus.m_last, bus.m_i, bus.m_q} !== {1'b1, (b % 4 == 3), e}) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got v=%b l=%b i=%h q=%h, want v=1 l=%b i=%h q=%h",
                         b, bus.m_valid, bus.m_last, bus.m_i, bus.m_q, (b % 4 == 3), e[31:16], e[15:0]);
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_after: got v=%b want 0", bus.m_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] w;
        logic [31:0] e;
        int          b;
        int          stalls;
        w = 16'hC63E; b = 0; stalls = 0;
        @(negedge clk);
        bus.m_ready = 1'b1; bus.s_valid = 1'b1; bus.s_data = w;
        for (int cyc = 0; cyc < 12 && b < 4; cyc++) begin
            @(negedge clk);
            if (cyc == 0) bus.s_valid = 1'b0;
            #1;
            e = exp_sym(w[4*b +: 4]);
            $display("bp cycle %0d beat %0d: v=%b i=%h q=%h", cyc, b, bus.m_valid, bus.m_i, bus.m_q);
            n_cmp++;
            if ({bus.m_valid, bus.m_last, bus.m_i, bus.m_q} !== {1'b1, (b == 3), e}) begin
                n_fail++;
                $display("FAIL bp_cycle%0d_beat%0d: got v=%b l=%b i=%h q=%h, want v=1 l=%b i=%h q=%h",
                         cyc, b, bus.m_valid, bus.m_last, bus.m_i, bus.m_q, (b == 3), e[31:16], e[15:0]);
            end
            if (b == 1 && stalls < 3) begin
                bus.m_ready = 1'b0;
                bus.s_valid = 1'b1;
                stalls++;
                #1;
                n_cmp++;
                if (bus.s_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_sready_stall%0d: got %b want 0", stalls, bus.s_ready);
                end
                bus.s_valid = 1'b0;
            end else begin
                bus.m_ready = 1'b1;
                b++;
            end
        end
        n_cmp++;
        if (b != 4) begin
            n_fail++;
            $display("FAIL bp_complete: got %0d beats want 4", b);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle_after: got v=%b want 0", bus.m_valid);
        end
    endtask

    task automatic test_enable;
        logic [15:0] w;
        logic [15:0] w_next;
        logic [31:0] e;
        w = 16'h9D27; w_next = 16'h0F0F;
        @(negedge clk);
        enable = 1'b1; bus.m_ready = 1'b1; bus.s_valid = 1'b1; bus.s_data = w;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) begin enable = 1'b0; bus.s_data = w_next; end
            #1;
            e = exp_sym(w[4*b +: 4]);
            $display("enable beat %0d: v=%b l=%b i=%h q=%h s_ready=%b", b, bus.m_valid, bus.m_last, bus.m_i, bus.m_q, bus.s_ready);
            n_cmp++;
            if ({bus.m_valid, bus.m_last, bus.m_i, bus.m_q, bus.s_ready} !== {1'b1, (b == 3), e, 1'b0}) begin
                n_fail++;
                $display("FAIL en_beat%0d: got v=%b l=%b i=%h q=%h s_ready=%b, want v=1 l=%b i=%h q=%h s_ready=0",
                         b, bus.m_valid, bus.m_last, bus.m_i, bus.m_q, bus.s_ready, (b == 3), e[31:16], e[15:0]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({bus.m_valid, busy, bus.s_ready} !== 3'b000) begin
                n_fail++;
                $display("FAIL en_blocked%0d: got v=%b busy=%b s_ready=%b, want 0 0 0",
                         c, bus.m_valid, busy, bus.s_ready);
            end
        end
        enable = 1'b1;
        #1;
        n_cmp++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL en_reenabled: got s_ready=%b want 1", bus.s_ready);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) bus.s_valid = 1'b0;
            #1;
            $display("enable resume beat %0d: i=%h q=%h", b, bus.m_i, bus.m_q);
            n_cmp++;
            if ({bus.m_valid, bus.m_last, bus.m_i, bus.m_q} !== {1'b1, (b == 3), ((b % 2 == 0) ? {NA3, NA3} : {A, A})}) begin
                n_fail++;
                $display("FAIL en_resume_beat%0d: got v=%b l=%b i=%h q=%h", b, bus.m_valid, bus.m_last, bus.m_i, bus.m_q);
            end
        end
    endtask

    task automatic test_reset_mid_word;
        logic [15:0] w;
        logic [31:0] e;
        w = 16'h4B1E;
        @(negedge clk);
        enable = 1'b1; bus.m_ready = 1'b1; bus.s_valid = 1'b1; bus.s_data = w;
        @(negedge clk);
        bus.s_valid = 1'b0;
        @(negedge clk);
        #1;
        e = exp_sym(w[7:4]);
        n_cmp++;
        if ({bus.m_valid, bus.m_i, bus.m_q} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL rst_pre_beat1: got v=%b i=%h q=%h, want v=1 i=%h q=%h",
                     bus.m_valid, bus.m_i, bus.m_q, e[31:16], e[15:0]);
        end
        #1 rst_n = 1'b0;
        #1;
        $display("reset mid-word: v=%b i=%h q=%h busy=%b", bus.m_valid, bus.m_i, bus.m_q, busy);
        n_cmp++;
        if ({bus.m_valid, bus.m_last, bus.m_i, bus.m_q, busy} !== 35'h0) begin
            n_fail++;
            $display("FAIL rst_async_clear: got v=%b l=%b i=%h q=%h busy=%b, want all 0",
                     bus.m_valid, bus.m_last, bus.m_i, bus.m_q, busy);
        end
        @(negedge clk);
        rst_n = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'h0006;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) bus.s_valid = 1'b0;
            #1;
            $display("post-reset beat %0d: i=%h q=%h", b, bus.m_i, bus.m_q);
            n_cmp++;
            if ({bus.m_valid, bus.m_last, bus.m_i, bus.m_q} !== {1'b1, (b == 3), ((b == 0) ? {A3, NA} : {A, A})}) begin
                n_fail++;
                $display("FAIL rst_post_beat%0d: got v=%b l=%b i=%h q=%h", b, bus.m_valid, bus.m_last, bus.m_i, bus.m_q);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_nibble_sweep;
        test_back_to_back;
        test_backpressure;
        test_enable;
        test_reset_mid_word;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
